regfile_superscalar: RTL and testbench

- Parametrised successor of the single-issue tagged register file.
- Holds 32 architectural values plus a per-register busy bit and ROB tag.
- Serves DISPATCH_W rename/read slots and COMMIT_W writeback slots per cycle, with in-group dependency forwarding and commit bypass.
- Sits between decode/rename and the reservation stations; the ROB drives the commit ports and the flush.

---
 rtl/regfile_superscalar_pkg.sv | 22 ++
 rtl/regfile_superscalar_src_sel.sv | 83 ++++++++
 rtl/regfile_superscalar.sv | 152 +++++++++++++++
 tb/tb_regfile_superscalar.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_superscalar_pkg.sv
// Shared types for the superscalar tagged register file.
//   NUM_ARCH_REGS : number of architectural integer registers (x0..x31)
//   RF_XLEN       : default data width
//   RF_TAG_W      : default ROB tag width (32-entry ROB)
//   rf_entry_t    : one register-file entry at the default widths
//                   (architectural value, busy bit, ROB tag of the producer)
package rv32i_types;

    localparam int NUM_ARCH_REGS = 32;
    localparam int RF_XLEN       = 32;
    localparam int RF_TAG_W      = 5;

    typedef struct packed {
        logic [RF_XLEN-1:0]  val;
        logic                busy;
        logic [RF_TAG_W-1:0] tag;
    } rf_entry_t;

    // Index of an architectural register.
    typedef logic [$clog2(NUM_ARCH_REGS)-1:0] arch_reg_t;

endpackage

// File: rtl/regfile_superscalar_src_sel.sv
// Combinational source-operand selector for one operand of one dispatch slot.
// Priority, highest first:
//   1. rs == x0                         -> value 0, not busy
//   2. older slot in the same group renames rs -> its tag, busy
//   3. commit in this cycle resolves the current producer of rs -> commit value
//   4. register array: tag if busy, else architectural value
// Ports:
//   rs                                   source register of this operand
//   disp_valid/disp_rd_we/disp_rd/disp_tag  the whole dispatch group
//   commit_valid/commit_rd/commit_tag/commit_v  the whole commit group
//   arr_val/arr_busy/arr_tag             current array entry for rs
//   src_v/src_busy                       selected operand
module regfile_src_sel
    import rv32i_types::*;
#(
    parameter int SLOT       = 0,
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int TAG_W      = 5,
    parameter int XLEN       = 32
) (
    input  logic [4:0]                           rs,
    input  logic [DISPATCH_W-1:0]                disp_valid,
    input  logic [DISPATCH_W-1:0]                disp_rd_we,
    input  logic [DISPATCH_W-1:0][4:0]           disp_rd,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]     disp_tag,
    input  logic [COMMIT_W-1:0]                  commit_valid,
    input  logic [COMMIT_W-1:0][4:0]             commit_rd,
    input  logic [COMMIT_W-1:0][TAG_W-1:0]       commit_tag,
    input  logic [COMMIT_W-1:0][XLEN-1:0]        commit_v,
    input  logic [XLEN-1:0]                      arr_val,
    input  logic                                 arr_busy,
    input  logic [TAG_W-1:0]                     arr_tag,
    output logic [XLEN-1:0]                      src_v,
    output logic                                 src_busy
);

    logic             fwd_hit;
    logic [TAG_W-1:0] fwd_tag;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_v;

    always_comb begin
        fwd_hit = 1'b0;
        fwd_tag = '0;
        // Only strictly older slots forward; ascending loop lets the
        // youngest older writer win.
        for (int j = 0; j < DISPATCH_W; j++) begin
            if (j < SLOT && disp_valid[j] && disp_rd_we[j] && disp_rd[j] == rs) begin
                fwd_hit = 1'b1;
                fwd_tag = disp_tag[j];
            end
        end

        byp_hit = 1'b0;
        byp_v   = '0;
        // A commit only bypasses when it is the producer the array is waiting on.
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k] && arr_busy && commit_rd[k] == rs && commit_tag[k] == arr_tag) begin
                byp_hit = 1'b1;
                byp_v   = commit_v[k];
            end
        end

        if (rs == 5'd0) begin
            src_v    = '0;
            src_busy = 1'b0;
        end else if (fwd_hit) begin
            src_v    = {{(XLEN-TAG_W){1'b0}}, fwd_tag};
            src_busy = 1'b1;
        end else if (byp_hit) begin
            src_v    = byp_v;
            src_busy = 1'b0;
        end else if (arr_busy) begin
            src_v    = {{(XLEN-TAG_W){1'b0}}, arr_tag};
            src_busy = 1'b1;
        end else begin
            src_v    = arr_val;
            src_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_superscalar.sv
// Superscalar tagged register file: 32 architectural values with a busy bit
// and producer ROB tag each. DISPATCH_W rename/read slots and COMMIT_W
// writeback slots per cycle, with in-group forwarding and commit bypass.
// Ports:
//   clk, rst (sync, active-high), flush (clears all busy/tag state)
//   disp_*   : dispatch group (valid, rd_we, rd, tag, rs1, rs2), slot 0 oldest
//   src_valid, rs1_v/rs1_busy, rs2_v/rs2_busy : registered source operands
//   commit_* : commit group (valid, rd, tag, value), slot 0 oldest
module regfile_superscalar
    import rv32i_types::*;
#(
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int ROB_DEPTH  = 32,
    parameter int TAG_W      = $clog2(ROB_DEPTH),
    parameter int XLEN       = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [DISPATCH_W-1:0]             disp_valid,
    input  logic [DISPATCH_W-1:0]             disp_rd_we,
    input  logic [DISPATCH_W-1:0][4:0]        disp_rd,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]  disp_tag,
    input  logic [DISPATCH_W-1:0][4:0]        disp_rs1,
    input  logic [DISPATCH_W-1:0][4:0]        disp_rs2,
    output logic [DISPATCH_W-1:0]             src_valid,
    output logic [DISPATCH_W-1:0][XLEN-1:0]   rs1_v,
    output logic [DISPATCH_W-1:0][XLEN-1:0]   rs2_v,
    output logic [DISPATCH_W-1:0]             rs1_busy,
    output logic [DISPATCH_W-1:0]             rs2_busy,
    input  logic [COMMIT_W-1:0]               commit_valid,
    input  logic [COMMIT_W-1:0][4:0]          commit_rd,
    input  logic [COMMIT_W-1:0][TAG_W-1:0]    commit_tag,
    input  logic [COMMIT_W-1:0][XLEN-1:0]     commit_v
);

    logic [XLEN-1:0]  val_reg  [NUM_ARCH_REGS];
    logic             busy_reg [NUM_ARCH_REGS];
    logic [TAG_W-1:0] tag_reg  [NUM_ARCH_REGS];

    logic [XLEN-1:0]  val_next  [NUM_ARCH_REGS];
    logic             busy_next [NUM_ARCH_REGS];
    logic [TAG_W-1:0] tag_next  [NUM_ARCH_REGS];

    // Update order encodes priority: commits in ascending slot order (highest
    // wins), then flush or dispatch on top so renames override commit clears.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            val_next[r]  = val_reg[r];
            busy_next[r] = busy_reg[r];
            tag_next[r]  = tag_reg[r];
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k] && commit_rd[k] != 5'd0) begin
                val_next[commit_rd[k]] = commit_v[k];
                // Stale commits restore the original busy bit, so a higher
                // stale slot also cancels a lower matching clear.
                busy_next[commit_rd[k]] = (tag_reg[commit_rd[k]] == commit_tag[k])
                                          ? 1'b0 : busy_reg[commit_rd[k]];
            end
        end

        if (flush) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                busy_next[r] = 1'b0;
                tag_next[r]  = '0;
            end
        end else begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid[i] && disp_rd_we[i] && disp_rd[i] != 5'd0) begin
                    busy_next[disp_rd[i]] = 1'b1;
                    tag_next[disp_rd[i]]  = disp_tag[i];
                end
            end
        end

        val_next[0]  = '0;
        busy_next[0] = 1'b0;
        tag_next[0]  = '0;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            if (rst) begin
                val_reg[r]  <= '0;
                busy_reg[r] <= 1'b0;
                tag_reg[r]  <= '0;
            end else begin
                val_reg[r]  <= val_next[r];
                busy_reg[r] <= busy_next[r];
                tag_reg[r]  <= tag_next[r];
            end
        end
    end

    logic [DISPATCH_W-1:0][XLEN-1:0] rs1_sel_v;
    logic [DISPATCH_W-1:0][XLEN-1:0] rs2_sel_v;
    logic [DISPATCH_W-1:0]           rs1_sel_busy;
    logic [DISPATCH_W-1:0]           rs2_sel_busy;

    generate
        for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_slot
            regfile_src_sel #(
                .SLOT(gi), .DISPATCH_W(DISPATCH_W), .COMMIT_W(COMMIT_W),
                .TAG_W(TAG_W), .XLEN(XLEN)
            ) u_sel_rs1 (
                .rs(disp_rs1[gi]),
                .disp_valid(disp_valid), .disp_rd_we(disp_rd_we),
                .disp_rd(disp_rd), .disp_tag(disp_tag),
                .commit_valid(commit_valid), .commit_rd(commit_rd),
                .commit_tag(commit_tag), .commit_v(commit_v),
                .arr_val(val_reg[disp_rs1[gi]]), .arr_busy(busy_reg[disp_rs1[gi]]),
                .arr_tag(tag_reg[disp_rs1[gi]]),
                .src_v(rs1_sel_v[gi]), .src_busy(rs1_sel_busy[gi])
            );

            regfile_src_sel #(
                .SLOT(gi), .DISPATCH_W(DISPATCH_W), .COMMIT_W(COMMIT_W),
                .TAG_W(TAG_W), .XLEN(XLEN)
            ) u_sel_rs2 (
                .rs(disp_rs2[gi]),
                .disp_valid(disp_valid), .disp_rd_we(disp_rd_we),
                .disp_rd(disp_rd), .disp_tag(disp_tag),
                .commit_valid(commit_valid), .commit_rd(commit_rd),
                .commit_tag(commit_tag), .commit_v(commit_v),
                .arr_val(val_reg[disp_rs2[gi]]), .arr_busy(busy_reg[disp_rs2[gi]]),
                .arr_tag(tag_reg[disp_rs2[gi]]),
                .src_v(rs2_sel_v[gi]), .src_busy(rs2_sel_busy[gi])
            );

            // Invalid slots and the flush cycle present all-zero operands.
            always_ff @(posedge clk) begin
                if (rst || flush || !disp_valid[gi]) begin
                    src_valid[gi] <= 1'b0;
                    rs1_v[gi]     <= '0;
                    rs1_busy[gi]  <= 1'b0;
                    rs2_v[gi]     <= '0;
                    rs2_busy[gi]  <= 1'b0;
                end else begin
                    src_valid[gi] <= 1'b1;
                    rs1_v[gi]     <= rs1_sel_v[gi];
                    rs1_busy[gi]  <= rs1_sel_busy[gi];
                    rs2_v[gi]     <= rs2_sel_v[gi];
                    rs2_busy[gi]  <= rs2_sel_busy[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_superscalar.sv
// Directed scoreboard bench for regfile_superscalar (2 dispatch, 2 commit).
module tb_regfile_superscalar;

    localparam int DW = 2;
    localparam int CW = 2;
    localparam int TW = 5;
    localparam int XL = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [DW-1:0]            disp_valid;
    logic [DW-1:0]            disp_rd_we;
    logic [DW-1:0][4:0]       disp_rd;
    logic [DW-1:0][TW-1:0]    disp_tag;
    logic [DW-1:0][4:0]       disp_rs1;
    logic [DW-1:0][4:0]       disp_rs2;
    logic [DW-1:0]            src_valid;
    logic [DW-1:0][XL-1:0]    rs1_v;
    logic [DW-1:0][XL-1:0]    rs2_v;
    logic [DW-1:0]            rs1_busy;
    logic [DW-1:0]            rs2_busy;
    logic [CW-1:0]            commit_valid;
    logic [CW-1:0][4:0]       commit_rd;
    logic [CW-1:0][TW-1:0]    commit_tag;
    logic [CW-1:0][XL-1:0]    commit_v;

    always #5 clk = ~clk;

    regfile_superscalar #(.DISPATCH_W(DW), .COMMIT_W(CW), .ROB_DEPTH(32), .XLEN(XL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_rd_we(disp_rd_we), .disp_rd(disp_rd),
        .disp_tag(disp_tag), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .src_valid(src_valid), .rs1_v(rs1_v), .rs2_v(rs2_v),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_v(commit_v)
    );

    typedef struct {
        string             name;
        logic [DW-1:0]     sv;
        logic [XL-1:0]     r1v [DW];
        logic [DW-1:0]     r1b;
        logic [XL-1:0]     r2v [DW];
        logic [DW-1:0]     r2b;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic clear_cur();
        cur.name = "";
        cur.sv   = '0;
        cur.r1b  = '0;
        cur.r2b  = '0;
        for (int s = 0; s < DW; s++) begin
            cur.r1v[s] = '0;
            cur.r2v[s] = '0;
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0;
        disp_valid = '0; disp_rd_we = '0; disp_rd = '0; disp_tag = '0;
        disp_rs1 = '0; disp_rs2 = '0;
        commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_v = '0;
    endtask

    task automatic disp(input int s, input bit we, input int rd, input int tag, input int rs1, input int rs2);
        disp_valid[s] = 1'b1;
        disp_rd_we[s] = we;
        disp_rd[s]    = 5'(rd);
        disp_tag[s]   = TW'(tag);
        disp_rs1[s]   = 5'(rs1);
        disp_rs2[s]   = 5'(rs2);
    endtask

    task automatic cmt(input int k, input int rd, input int tag, input logic [XL-1:0] v);
        commit_valid[k] = 1'b1;
        commit_rd[k]    = 5'(rd);
        commit_tag[k]   = TW'(tag);
        commit_v[k]     = v;
    endtask

    task automatic want(input int s, input logic [XL-1:0] v1, input bit b1, input logic [XL-1:0] v2, input bit b2);
        cur.sv[s]  = 1'b1;
        cur.r1v[s] = v1;
        cur.r1b[s] = b1;
        cur.r2v[s] = v2;
        cur.r2b[s] = b2;
    endtask

    // Push the expectation for the inputs now applied, clock once, then
    // compare the registered outputs against the popped entry.
    task automatic step(input string name);
        exp_t e;
        cur.name = name;
        exp_q.push_back(cur);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        for (int s = 0; s < DW; s++) begin
            check_val($sformatf("%s.s%0d.src_valid", e.name, s), XL'(src_valid[s]), XL'(e.sv[s]));
            check_val($sformatf("%s.s%0d.rs1_v", e.name, s), rs1_v[s], e.r1v[s]);
            check_val($sformatf("%s.s%0d.rs1_busy", e.name, s), XL'(rs1_busy[s]), XL'(e.r1b[s]));
            check_val($sformatf("%s.s%0d.rs2_v", e.name, s), rs2_v[s], e.r2v[s]);
            check_val($sformatf("%s.s%0d.rs2_busy", e.name, s), XL'(rs2_busy[s]), XL'(e.r2b[s]));
        end
        $display("vec %-14s s0: v=%0b r1=0x%0h/%0b r2=0x%0h/%0b  s1: v=%0b r1=0x%0h/%0b r2=0x%0h/%0b",
                 e.name, src_valid[0], rs1_v[0], rs1_busy[0], rs2_v[0], rs2_busy[0],
                 src_valid[1], rs1_v[1], rs1_busy[1], rs2_v[1], rs2_busy[1]);
        clear_inputs();
        clear_cur();
    endtask

    initial begin
        clear_inputs();
        clear_cur();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset still held, reads requested: everything must stay zero.
        rst = 1'b1; disp(0, 0, 0, 0, 5, 5); disp(1, 0, 0, 0, 5, 0);
        step("reset");

        disp(0, 0, 0, 0, 5, 0); disp(1, 0, 0, 0, 5, 5);
        want(0, 0, 0, 0, 0); want(1, 0, 0, 0, 0);
        step("read_x5");

        // Give x3 a known architectural value.
        cmt(0, 3, 0, 32'h33);
        step("init_x3");

        // Slot0 renames x3 -> 7; slot1 forwards the tag, slot0 sees old value.
        disp(0, 1, 3, 7, 3, 5); disp(1, 0, 0, 0, 3, 3);
        want(0, 32'h33, 0, 0, 0); want(1, 7, 1, 7, 1);
        step("fwd_x3");

        // Matching commit bypasses into a same-cycle read.
        cmt(0, 3, 7, 32'hDEAD); disp(0, 0, 0, 0, 3, 0);
        want(0, 32'hDEAD, 0, 0, 0);
        step("bypass_x3");

        disp(0, 0, 0, 0, 3, 0); disp(1, 0, 0, 0, 3, 0);
        want(0, 32'hDEAD, 0, 0, 0); want(1, 32'hDEAD, 0, 0, 0);
        step("after_commit");

        // Slot1 renames x3 -> 9 while reading it: no self-forward.
        disp(0, 0, 0, 0, 3, 0); disp(1, 1, 3, 9, 3, 0);
        want(0, 32'hDEAD, 0, 0, 0); want(1, 32'hDEAD, 0, 0, 0);
        step("rename_x3_9");

        // Stale commit (tag 7) must not bypass nor clear busy.
        cmt(0, 3, 7, 32'h11); disp(0, 0, 0, 0, 3, 0);
        want(0, 9, 1, 0, 0);
        step("stale_x3");

        disp(0, 0, 0, 0, 3, 0); disp(1, 1, 4, 5, 4, 0);
        want(0, 9, 1, 0, 0); want(1, 0, 0, 0, 0);
        step("x3_busy9");

        // Commit x4 tag5 while slot0 renames x4 -> 12.
        cmt(0, 4, 5, 32'h44); disp(0, 1, 4, 12, 4, 0); disp(1, 0, 0, 0, 4, 0);
        want(0, 32'h44, 0, 0, 0); want(1, 12, 1, 0, 0);
        step("x4_cmt_disp");

        disp(0, 0, 0, 0, 4, 3);
        want(0, 12, 1, 9, 1);
        step("x4_busy12");

        // Two slots rename x6: the younger slot wins.
        disp(0, 1, 6, 1, 0, 0); disp(1, 1, 6, 2, 0, 0);
        want(0, 0, 0, 0, 0); want(1, 0, 0, 0, 0);
        step("dual_rename");

        disp(0, 0, 0, 0, 6, 0);
        want(0, 2, 1, 0, 0);
        step("x6_tag2");

        // k0 matches, k1 stale to the same rd: k1 owns value and busy.
        cmt(0, 6, 2, 32'h60); cmt(1, 6, 1, 32'h61); disp(0, 0, 0, 0, 6, 0);
        want(0, 32'h60, 0, 0, 0);
        step("dual_cmt_a");

        disp(0, 0, 0, 0, 6, 0);
        want(0, 2, 1, 0, 0);
        step("x6_still_busy");

        cmt(0, 6, 1, 32'h70); cmt(1, 6, 2, 32'h71); disp(0, 0, 0, 0, 6, 0);
        want(0, 32'h71, 0, 0, 0);
        step("dual_cmt_b");

        disp(0, 0, 0, 0, 6, 0);
        want(0, 32'h71, 0, 0, 0);
        step("x6_clear");

        disp(0, 1, 1, 3, 0, 0); disp(1, 1, 2, 4, 0, 0);
        want(0, 0, 0, 0, 0); want(1, 0, 0, 0, 0);
        step("busy_x1_x2");

        // Flush with commits and dispatch: renames dropped, values written.
        flush = 1'b1;
        cmt(0, 1, 3, 32'hA1); cmt(1, 2, 4, 32'hA2);
        disp(0, 1, 1, 8, 1, 2); disp(1, 1, 2, 10, 2, 1);
        step("flush");

        disp(0, 0, 0, 0, 1, 2); disp(1, 0, 0, 0, 4, 3);
        want(0, 32'hA1, 0, 32'hA2, 0); want(1, 32'h44, 0, 32'h11, 0);
        step("post_flush");

        // x0 is never renamed or written; invalid slot 1 outputs zero.
        cmt(0, 0, 0, 32'hFF); disp(0, 1, 0, 5, 0, 0);
        disp_rs1[1] = 5'd1;
        want(0, 0, 0, 0, 0);
        step("x0_write");

        disp(0, 0, 0, 0, 0, 1);
        want(0, 0, 0, 32'hA1, 0);
        step("x0_read");

        disp(0, 1, 1, 5, 0, 0);
        want(0, 0, 0, 0, 0);
        step("rename_x1");

        rst = 1'b1; disp(0, 0, 0, 0, 1, 6);
        step("mid_reset");

        disp(0, 0, 0, 0, 1, 6); disp(1, 0, 0, 0, 3, 4);
        want(0, 0, 0, 0, 0); want(1, 0, 0, 0, 0);
        step("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
